code_lock_fsm: RTL and testbench

Parametrised directional-keypad combination lock. It takes one-cycle N/W/S/E press pulses and checks them against a stored code of CODE_LEN symbols. It counts failed attempts, raises a flashing alarm after MAX_FAILS failures, and, when configured, lets the user reprogram the code while unlocked. It sits between the debounced/edge-detected button front end and the board LEDs/RGB.

---
 rtl/lock_pkg.sv | 60 ++++++
 rtl/blink_div.sv | 47 ++++
 rtl/code_lock_fsm.sv | 252 +++++++++++++++++++++++++
 tb/tb_code_lock_fsm.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// ============================================================================
// Module      : lock_pkg
// Description : Shared types and constants for the code_lock_fsm keypad lock:
//               state enum, keypad symbol codes, RGB colours, decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lock_pkg;

    // Lock controller states
    typedef enum logic [2:0] {
        LOCKED   = 3'd0,
        ENTRY    = 3'd1,
        UNLOCKED = 3'd2,
        PROG     = 3'd3,
        ALARM    = 3'd4,
        DISARM   = 3'd5
    } lock_state_t;

    // Two-bit symbol codes stored in the code register
    localparam logic [1:0] SYM_N = 2'd3;
    localparam logic [1:0] SYM_W = 2'd2;
    localparam logic [1:0] SYM_S = 2'd1;
    localparam logic [1:0] SYM_E = 2'd0;

    // Status colours, bit order {red, green, blue}
    localparam logic [2:0] RGB_OFF   = 3'b000;
    localparam logic [2:0] RGB_BLUE  = 3'b001;
    localparam logic [2:0] RGB_GREEN = 3'b010;

    // Map a one-hot press vector to its symbol code; callers qualify with a
    // one-hot check, so the fall-through value is never trusted.
    function automatic logic [1:0] sym_of(input logic [3:0] nwse);
        logic [1:0] sym;
        case (nwse)
            4'b1000: sym = SYM_N;
            4'b0100: sym = SYM_W;
            4'b0010: sym = SYM_S;
            default: sym = SYM_E;
        endcase
        return sym;
    endfunction

    // Progress bar: thermometer code of min(n, 4)
    function automatic logic [3:0] therm4(input logic [2:0] n);
        logic [3:0] t;
        case (n)
            3'd0:    t = 4'b0000;
            3'd1:    t = 4'b0001;
            3'd2:    t = 4'b0011;
            3'd3:    t = 4'b0111;
            default: t = 4'b1111;
        endcase
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/blink_div.sv
// ============================================================================
// Module      : blink_div
// Description : Free-running blink divider. Counts while en is high and
//               toggles blink each time the counter wraps; half selects one
//               extra counter bit (half blink rate). Cleared while en is low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module blink_div #(
    parameter int WIDTH = 23
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic half,
    output logic blink
);

    logic [WIDTH:0] cnt_q;
    logic           blink_q;
    logic           wrap_w;

    // Wrap point depends on whether the extra top bit participates
    assign wrap_w = half ? (&cnt_q) : (&cnt_q[WIDTH-1:0]);
    assign blink  = blink_q;

    // Divider counter and blink toggle; held at zero whenever disabled
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            if (half) begin
                cnt_q <= cnt_q + (WIDTH+1)'(1);
            end else begin
                cnt_q <= {1'b0, cnt_q[WIDTH-1:0] + WIDTH'(1)};
            end
            if (wrap_w) begin
                blink_q <= ~blink_q;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/code_lock_fsm.sv
// ============================================================================
// Module      : code_lock_fsm
// Description : Directional-keypad combination lock. Checks one-cycle N/W/S/E
//               press pulses against a stored code, counts failed attempts,
//               raises a flashing alarm after MAX_FAILS failures.
//               Optional macro LOCK_PROGRAM_EN: reprogram the code from
//               UNLOCKED (press N, then CODE_LEN symbols).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module code_lock_fsm
    import lock_pkg::*;
#(
    parameter int                      CODE_LEN       = 4,
    parameter int                      MAX_FAILS      = 3,
    parameter logic [2*CODE_LEN-1:0]   DEFAULT_CODE   = 8'h89,
    parameter int                      TIMEOUT_CYCLES = 0,
    parameter int                      FLASH_BITS     = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] nwse,
    output logic [3:0] led,
    output logic [2:0] rgb,
    output logic       unlocked,
    output logic       alarm
);

    localparam int                IDLE_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]        IDX_LAST  = 3'(CODE_LEN - 1);
    localparam logic [3:0]        FAIL_MAX  = 4'(MAX_FAILS);

    lock_state_t          state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic                 mismatch_q, mismatch_d;
    logic [3:0]           fail_q, fail_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;
    logic [2*CODE_LEN-1:0] code_w;

`ifdef LOCK_PROGRAM_EN
    logic [2*CODE_LEN-1:0] code_q, code_d;
    logic [2*CODE_LEN-1:0] newcode_q, newcode_d;
    assign code_w = code_q;
`else
    assign code_w = DEFAULT_CODE;
`endif

    logic       press_w;
    logic       valid_w;
    logic [1:0] sym_w;
    logic [1:0] exp_sym_w;
    logic       hit_w;
    logic       miss_any_w;
    logic       last_w;
    logic       timeout_w;
    logic [3:0] fail_inc_w;
    logic       blink_w;
    logic       blink_en_w;
    logic       blink_half_w;

    assign press_w    = |nwse;
    assign valid_w    = $onehot(nwse);
    assign sym_w      = sym_of(nwse);
    assign exp_sym_w  = code_w[{idx_q, 1'b0} +: 2];
    assign hit_w      = valid_w && (sym_w == exp_sym_w);
    assign miss_any_w = mismatch_q | ~hit_w;
    assign last_w     = (idx_q == IDX_LAST);
    assign timeout_w  = (TIMEOUT_CYCLES != 0) && !press_w && (idle_q == IDLE_LAST);
    // Saturating failure increment
    assign fail_inc_w = (fail_q >= FAIL_MAX) ? FAIL_MAX : (fail_q + 4'd1);

    // Next-state and datapath decisions for one press (or idle) cycle
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mismatch_d = mismatch_q;
        fail_d     = fail_q;
        idle_d     = '0;
`ifdef LOCK_PROGRAM_EN
        code_d     = code_q;
        newcode_d  = newcode_q;
`endif
        case (state_q)
            LOCKED: begin
                idx_d      = 3'd0;
                mismatch_d = 1'b0;
                if (press_w) begin
                    mismatch_d = ~hit_w;
                    idx_d      = 3'd1;
                    state_d    = ENTRY;
                end
            end
            ENTRY: begin
                if (press_w) begin
                    if (last_w) begin
                        idx_d      = 3'd0;
                        mismatch_d = 1'b0;
                        if (!miss_any_w) begin
                            state_d = UNLOCKED;
                            fail_d  = 4'd0;
                        end else begin
                            fail_d  = fail_inc_w;
                            state_d = (fail_inc_w == FAIL_MAX) ? ALARM : LOCKED;
                        end
                    end else begin
                        idx_d      = idx_q + 3'd1;
                        mismatch_d = miss_any_w;
                    end
                end else if (timeout_w) begin
                    // Abandoned attempt; deliberately not counted as a failure
                    state_d    = LOCKED;
                    idx_d      = 3'd0;
                    mismatch_d = 1'b0;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            UNLOCKED: begin
                if (press_w) begin
`ifdef LOCK_PROGRAM_EN
                    if (nwse == 4'b1000) begin
                        state_d = PROG;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = LOCKED;
                    end
`else
                    state_d = LOCKED;
`endif
                end
            end
`ifdef LOCK_PROGRAM_EN
            PROG: begin
                if (press_w) begin
                    if (!valid_w) begin
                        state_d = UNLOCKED;
                        idx_d   = 3'd0;
                    end else begin
                        newcode_d[{idx_q, 1'b0} +: 2] = sym_w;
                        if (last_w) begin
                            code_d  = newcode_d;
                            state_d = LOCKED;
                            idx_d   = 3'd0;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
            end
`endif
            ALARM: begin
                if (nwse == 4'b0100) begin
                    state_d = DISARM;
                end
            end
            DISARM: begin
                if (press_w) begin
                    if (nwse == 4'b0001) begin
                        state_d = LOCKED;
                        fail_d  = 4'd0;
                    end else begin
                        state_d = ALARM;
                    end
                end
            end
            default: begin
                state_d = LOCKED;
                idx_d   = 3'd0;
            end
        endcase
        if (state_d != state_q) begin
            idle_d = '0;
        end
    end

    // Controller state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOCKED;
            idx_q      <= 3'd0;
            mismatch_q <= 1'b0;
            fail_q     <= 4'd0;
            idle_q     <= '0;
`ifdef LOCK_PROGRAM_EN
            code_q     <= DEFAULT_CODE;
            newcode_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mismatch_q <= mismatch_d;
            fail_q     <= fail_d;
            idle_q     <= idle_d;
`ifdef LOCK_PROGRAM_EN
            code_q     <= code_d;
            newcode_q  <= newcode_d;
`endif
        end
    end

    // Divider runs only while staying in a flashing state, so every entry
    // (including ALARM <-> DISARM) starts from a cleared counter.
    assign blink_en_w   = ((state_q == UNLOCKED) || (state_q == ALARM) || (state_q == DISARM))
                          && (state_d == state_q);
    assign blink_half_w = (state_q == DISARM);

    blink_div #(
        .WIDTH (FLASH_BITS)
    ) u_blink (
        .clk   (clk),
        .rst   (rst),
        .en    (blink_en_w),
        .half  (blink_half_w),
        .blink (blink_w)
    );

    // Output decode from registered state
    always_comb begin
        led      = 4'h0;
        rgb      = RGB_OFF;
        unlocked = 1'b0;
        alarm    = 1'b0;
        case (state_q)
            LOCKED: begin
                rgb = RGB_BLUE;
            end
            ENTRY: begin
                led = therm4(idx_q);
            end
            PROG: begin
                led = therm4(idx_q);
                rgb = RGB_GREEN;
            end
            UNLOCKED: begin
                led      = blink_w ? 4'hF : 4'h0;
                unlocked = 1'b1;
            end
            ALARM, DISARM: begin
                rgb   = {blink_w, 2'b00};
                alarm = 1'b1;
            end
            default: begin
                rgb = RGB_BLUE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_code_lock_fsm.sv
// ============================================================================
// Module      : tb_code_lock_fsm
// Description : Self-checking bench for code_lock_fsm. Directed scenarios then
//               randomized presses, every cycle compared against a behavioural
//               model (entered-symbol queues, time-in-state blink).
//               Follows LOCK_PROGRAM_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_code_lock_fsm;

    localparam int         CL = 4;
    localparam int         MF = 3;
    localparam int         TO = 10;
    localparam int         FB = 2;
    localparam logic [7:0] DC = 8'h89;

    localparam logic [3:0] KN = 4'b1000;
    localparam logic [3:0] KW = 4'b0100;
    localparam logic [3:0] KS = 4'b0010;
    localparam logic [3:0] KE = 4'b0001;

    // Model modes (independent of the RTL encoding)
    localparam int M_LOCKED = 10, M_ENTRY = 11, M_OPEN = 12, M_PROG = 13, M_ALARM = 14, M_DISARM = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] nwse = 4'h0;
    logic [3:0] led;
    logic [2:0] rgb;
    logic       unlocked;
    logic       alarm;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    code_lock_fsm #(
        .CODE_LEN       (CL),
        .MAX_FAILS      (MF),
        .DEFAULT_CODE   (DC),
        .TIMEOUT_CYCLES (TO),
        .FLASH_BITS     (FB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .nwse     (nwse),
        .led      (led),
        .rgb      (rgb),
        .unlocked (unlocked),
        .alarm    (alarm)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_mode;
    int m_fail;
    int m_t;
    int m_idle;
    int m_code[CL];
    int m_entry[$];
    int m_new[$];

    function automatic int sym(input logic [3:0] n);
        case (n)
            KN:      return 3;
            KW:      return 2;
            KS:      return 1;
            KE:      return 0;
            default: return -1;
        endcase
    endfunction

    function automatic logic [3:0] key(input int s);
        return 4'(1 << s);
    endfunction

    function void model_reset();
        m_mode = M_LOCKED;
        m_fail = 0;
        m_t    = 0;
        m_idle = 0;
        m_entry.delete();
        m_new.delete();
        for (int i = 0; i < CL; i++) m_code[i] = int'((DC >> (2 * i)) & 8'h3);
    endfunction

    function void model_edge(input logic [3:0] n, input logic r);
        int  nm;
        int  s;
        bit  p;
        bit  ok;
        if (r) begin
            model_reset();
            return;
        end
        nm = m_mode;
        p  = (n != 4'h0);
        s  = sym(n);
        case (m_mode)
            M_LOCKED: if (p) begin
                m_entry.delete();
                m_entry.push_back(s);
                nm = M_ENTRY;
            end
            M_ENTRY: begin
                if (p) begin
                    m_entry.push_back(s);
                    if (m_entry.size() == CL) begin
                        ok = 1;
                        for (int i = 0; i < CL; i++) if (m_entry[i] != m_code[i]) ok = 0;
                        if (ok) begin
                            nm = M_OPEN;
                            m_fail = 0;
                        end else begin
                            m_fail = (m_fail + 1 > MF) ? MF : m_fail + 1;
                            nm = (m_fail == MF) ? M_ALARM : M_LOCKED;
                        end
                    end
                end else begin
                    m_idle++;
                    if (m_idle >= TO) nm = M_LOCKED;
                end
            end
            M_OPEN: if (p) begin
`ifdef LOCK_PROGRAM_EN
                if (n == KN) begin
                    nm = M_PROG;
                    m_new.delete();
                end else nm = M_LOCKED;
`else
                nm = M_LOCKED;
`endif
            end
            M_PROG: if (p) begin
                if (s < 0) nm = M_OPEN;
                else begin
                    m_new.push_back(s);
                    if (m_new.size() == CL) begin
                        for (int i = 0; i < CL; i++) m_code[i] = m_new[i];
                        nm = M_LOCKED;
                    end
                end
            end
            M_ALARM: if (n == KW) nm = M_DISARM;
            M_DISARM: if (p) begin
                if (n == KE) begin
                    nm = M_LOCKED;
                    m_fail = 0;
                end else nm = M_ALARM;
            end
            default: nm = M_LOCKED;
        endcase
        if (p) m_idle = 0;
        if (nm != m_mode) begin
            m_idle = 0;
            m_t    = 0;
            if (nm != M_ENTRY) m_entry.delete();
        end else begin
            m_t++;
        end
        m_mode = nm;
    endfunction

    // Expected {led[3:0], rgb[2:0], unlocked, alarm}
    function automatic logic [8:0] model_out();
        logic [3:0] l;
        logic [2:0] c;
        logic       u;
        logic       a;
        logic       b;
        int         k;
        l = 4'h0; c = 3'b000; u = 1'b0; a = 1'b0;
        case (m_mode)
            M_LOCKED: c = 3'b001;
            M_ENTRY: begin
                k = (m_entry.size() > 4) ? 4 : m_entry.size();
                l = 4'((1 << k) - 1);
            end
            M_PROG: begin
                k = (m_new.size() > 4) ? 4 : m_new.size();
                l = 4'((1 << k) - 1);
                c = 3'b010;
            end
            M_OPEN: begin
                b = ((m_t >> FB) & 1) != 0;
                l = b ? 4'hF : 4'h0;
                u = 1'b1;
            end
            M_ALARM: begin
                b = ((m_t >> FB) & 1) != 0;
                c = {b, 2'b00};
                a = 1'b1;
            end
            default: begin
                b = ((m_t >> (FB + 1)) & 1) != 0;
                c = {b, 2'b00};
                a = 1'b1;
            end
        endcase
        return {l, c, u, a};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick(input logic [3:0] n, input logic r);
        logic [8:0] got;
        logic [8:0] exp;
        nwse = n;
        rst  = r;
        @(posedge clk);
        #1;
        cyc++;
        model_edge(n, r);
        exp = model_out();
        got = {led, rgb, unlocked, alarm};
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL outputs cyc=%0d nwse=%b rst=%b observed=%b expected=%b", cyc, n, r, got, exp);
        end
        nwse = 4'h0;
        rst  = 1'b0;
    endtask

    task automatic idle(input int c);
        for (int i = 0; i < c; i++) tick(4'h0, 1'b0);
    endtask

    task automatic seq4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        tick(a, 1'b0); tick(b, 1'b0); tick(c, 1'b0); tick(d, 1'b0);
    endtask

    task automatic chk(input string tag, input logic [8:0] observed, input logic [8:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [3:0] v;
        int         a;

        model_reset();
        tick(4'h0, 1'b1);
        chk("reset_outputs", {led, rgb, unlocked, alarm}, 9'b0000_001_0_0);

        // Correct code on separate cycles, then watch the unlock blink
        tick(KS, 1'b0); chk("led_after_S", {5'b0, led}, 9'b0_0000_0001);
        idle(1);
        tick(KW, 1'b0); chk("led_after_W", {5'b0, led}, 9'b0_0000_0011);
        idle(1);
        tick(KE, 1'b0); chk("led_after_E", {5'b0, led}, 9'b0_0000_0111);
        idle(1);
        tick(KW, 1'b0); chk("unlocked_after_code", {8'b0, unlocked}, 9'd1);
        idle(4);        chk("unlock_blink_on", {5'b0, led}, 9'h00F);
        idle(8);
        tick(KE, 1'b0); chk("relock_rgb", {6'b0, rgb}, 9'd1);

        // Three wrong attempts -> alarm
        seq4(KS, KW, KE, KN); chk("fail1_no_alarm", {8'b0, alarm}, 9'd0);
        seq4(KS, KW, KE, KN); chk("fail2_no_alarm", {8'b0, alarm}, 9'd0);
        seq4(KS, KW, KE, KN); chk("fail3_alarm", {8'b0, alarm}, 9'd1);
        idle(12);
        tick(KW, 1'b0); tick(KE, 1'b0);
        chk("disarm_rgb", {6'b0, rgb}, 9'd1);

        // Alarm again; W then S must fall back into ALARM
        repeat (3) seq4(KN, KN, KN, KN);
        tick(KW, 1'b0); idle(9);
        tick(KS, 1'b0); chk("disarm_abort", {8'b0, alarm}, 9'd1);
        idle(5);
        tick(KW, 1'b0); tick(KE, 1'b0);

        // A success clears the failure count
        seq4(KS, KW, KE, KN);
        seq4(KS, KW, KE, KW); chk("unlock_after_fail", {8'b0, unlocked}, 9'd1);
        tick(KS, 1'b0);
        seq4(KE, KE, KE, KE);
        seq4(KE, KE, KE, KE); chk("two_fails_after_clear", {8'b0, alarm}, 9'd0);
        seq4(KE, KE, KE, KE); chk("third_fail_alarm", {8'b0, alarm}, 9'd1);
        tick(KW, 1'b0); tick(KE, 1'b0);

`ifdef LOCK_PROGRAM_EN
        // Reprogram to N,N,E,E
        seq4(KS, KW, KE, KW);
        tick(KN, 1'b0); chk("prog_rgb", {6'b0, rgb}, 9'b0_0000_0010);
        seq4(KN, KN, KE, KE); chk("prog_commit_locked", {6'b0, rgb}, 9'd1);
        seq4(KS, KW, KE, KW); chk("old_code_rejected", {8'b0, unlocked}, 9'd0);
        seq4(KN, KN, KE, KE); chk("new_code_accepted", {8'b0, unlocked}, 9'd1);
        tick(KN, 1'b0); tick(KN, 1'b0); tick(4'b0011, 1'b0);
        chk("prog_abort_unlocked", {8'b0, unlocked}, 9'd1);
        tick(KE, 1'b0);
`endif

        // Timeout abandons the attempt without counting a failure
        seq4(KE, KE, KE, KE);
        tick(KS, 1'b0); idle(TO - 1);
        chk("entry_before_timeout", {5'b0, led}, 9'd1);
        idle(1);        chk("timeout_locked", {6'b0, rgb}, 9'd1);
        seq4(KE, KE, KE, KE); chk("timeout_not_counted", {8'b0, alarm}, 9'd0);
        seq4(KE, KE, KE, KE); chk("alarm_after_timeout", {8'b0, alarm}, 9'd1);

        // Reset during ALARM and mid-entry
        tick(4'h0, 1'b1); chk("reset_in_alarm", {led, rgb, unlocked, alarm}, 9'b0000_001_0_0);
        tick(KS, 1'b0); tick(KW, 1'b0);
        tick(KE, 1'b1); chk("reset_in_entry", {led, rgb, unlocked, alarm}, 9'b0000_001_0_0);

        // Randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            a = $urandom_range(0, 11);
            if ($urandom_range(0, 299) == 0) begin
                tick(4'h0, 1'b1);
            end else begin
                case (a)
                    0, 1, 2: tick(4'h0, 1'b0);
                    3, 4:    tick(key($urandom_range(0, 3)), 1'b0);
                    5: begin
                        v = 4'($urandom);
                        while ($countones(v) < 2) v = 4'($urandom);
                        tick(v, 1'b0);
                    end
                    6, 7: begin
                        for (int i = 0; i < CL; i++) begin
                            tick(key(m_code[i]), 1'b0);
                            if ($urandom_range(0, 3) == 0) tick(4'h0, 1'b0);
                        end
                    end
                    8: begin
                        tick(KW, 1'b0);
                        tick(KE, 1'b0);
                    end
                    9: idle(12);
                    10: begin
                        tick(KN, 1'b0);
                        for (int i = 0; i < CL; i++) tick(key($urandom_range(0, 3)), 1'b0);
                    end
                    default: begin
                        for (int i = 0; i < CL; i++) tick(key($urandom_range(0, 3)), 1'b0);
                    end
                endcase
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
